// File: rtl/adc_stream_pkg.sv
// Shared types and helpers for the ADC stream packetizer.
package adc_stream_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSrun,
    StGarm,
    StGrun,
    StOvf
  } state_e;

  localparam int unsigned MaxKeepW = 128;

  // Byte-enable mask covering the given number of filled lanes (rounded up to whole bytes).
  function automatic logic [MaxKeepW-1:0] keep_for_lanes(int unsigned lanes,
                                                         int unsigned sample_w);
    logic [MaxKeepW-1:0] mask;
    int unsigned nbytes;
    nbytes = (lanes * sample_w + 7) / 8;
    mask = '0;
    for (int unsigned i = 0; i < MaxKeepW; i++) begin
      mask[i] = (i < nbytes);
    end
    return mask;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO succeeds when a pop
// happens in the same cycle.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_wr, do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd   = rd_en_i && !empty_o;
  assign do_wr   = wr_en_i && (!full_o || do_rd);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/adc_stream_packetizer.sv
// Packs ADC samples into AXI-Stream beats, framing single-shot or sync-gated packets,
// with a test-pattern source and overflow termination.
module adc_stream_packetizer
  import adc_stream_pkg::*;
#(
  parameter int unsigned SAMPLE_W         = 16,
  parameter int unsigned SAMPLES_PER_BEAT = 2,
  parameter int unsigned FIFO_DEPTH       = 512,
  parameter int unsigned CNT_W            = 32,
  localparam int unsigned DATA_W          = SAMPLE_W * SAMPLES_PER_BEAT,
  localparam int unsigned KEEP_W          = DATA_W / 8
) (
  input  logic                m00_axis_aclk,
  input  logic                m00_axis_aresetn,
  input  logic                s_sample_valid,
  input  logic [SAMPLE_W-1:0] s_sample_data,
  output logic                m00_axis_tvalid,
  output logic [DATA_W-1:0]   m00_axis_tdata,
  output logic [KEEP_W-1:0]   m00_axis_tkeep,
  output logic                m00_axis_tlast,
  input  logic                m00_axis_tready,
  input  logic [CNT_W-1:0]    dsize,
  input  logic                test,
  input  logic                start,
  input  logic                start_rt,
  input  logic                sync,
  input  logic                abort,
  output logic                sr_pc,
  output logic                overflow,
  output logic [CNT_W-1:0]    ovf_count
);

  localparam int unsigned LANE_W  = (SAMPLES_PER_BEAT > 1) ? $clog2(SAMPLES_PER_BEAT) : 1;
  localparam int unsigned ENTRY_W = 1 + KEEP_W + DATA_W;
  localparam logic [LANE_W-1:0] LastLane = LANE_W'(SAMPLES_PER_BEAT - 1);
  localparam logic [KEEP_W-1:0] KeepAll  = '1;

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d, dsize_q, dsize_d, ovf_count_q, ovf_count_d;
  logic [SAMPLE_W-1:0] tcnt_q, tcnt_d;
  logic [ENTRY_W-1:0]  pend_q, pend_d, wbeat_q, wbeat_d;
  logic                pend_valid_q, pend_valid_d, wvalid_q, wvalid_d;
  logic                overflow_q, overflow_d, sr_pc_q, sr_pc_d;

  logic                fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  fifo_din, fifo_dout;
  logic [SAMPLE_W-1:0] lane_data;
  logic [DATA_W-1:0]   beat_full;
  logic [KEEP_W-1:0]   partial_keep;
  logic                lane_last, capture, arm, gated, drop, term;

  assign fifo_rd   = m00_axis_tready && !fifo_empty;
  // A registered beat that cannot enter the FIFO this cycle is lost.
  assign drop      = wvalid_q && fifo_full && !fifo_rd;
  assign term      = (state_q == StOvf) && (!fifo_full || fifo_rd);
  assign lane_data = test ? tcnt_q : s_sample_data;
  assign lane_last = (lane_q == LastLane);

  always_comb begin
    beat_full = acc_q;
    beat_full[lane_q*SAMPLE_W +: SAMPLE_W] = lane_data;
    partial_keep = KEEP_W'(keep_for_lanes(32'(lane_q), SAMPLE_W));
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) state_q <= StIdle;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    acc_d        = acc_q;
    beat_cnt_d   = beat_cnt_q;
    dsize_d      = dsize_q;
    tcnt_d       = tcnt_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    wbeat_d      = wbeat_q;
    wvalid_d     = 1'b0;
    overflow_d   = overflow_q;
    ovf_count_d  = ovf_count_q;
    capture      = 1'b0;
    arm          = 1'b0;
    gated        = 1'b0;
    case (state_q)
      StIdle: begin
        // Final beat of a gated packet left behind in PEND by the close.
        if (pend_valid_q) begin
          wbeat_d      = pend_q;
          wvalid_d     = 1'b1;
          pend_valid_d = 1'b0;
        end
        if (start_rt) begin
          state_d = StGarm;
          arm     = 1'b1;
        end else if (start && (dsize != '0)) begin
          state_d = StSrun;
          dsize_d = dsize;
          arm     = 1'b1;
        end
      end
      StSrun: begin
        capture = s_sample_valid;
        if (capture && lane_last) begin
          wbeat_d    = {(beat_cnt_q == dsize_q - 1'b1), KeepAll, beat_full};
          wvalid_d   = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == dsize_q - 1'b1) state_d = StIdle;
        end
      end
      StGarm: begin
        gated   = 1'b1;
        capture = s_sample_valid && sync;
        if (capture) state_d = StGrun;
      end
      StGrun: begin
        gated = 1'b1;
        if (sync) begin
          capture = s_sample_valid;
        end else begin
          if (lane_q != '0) begin
            if (pend_valid_q) begin
              wbeat_d = pend_q;
              pend_d  = {1'b1, partial_keep, acc_q};
            end else begin
              wbeat_d = {1'b1, partial_keep, acc_q};
            end
            wvalid_d = 1'b1;
          end else if (pend_valid_q) begin
            wbeat_d      = {1'b1, pend_q[ENTRY_W-2:0]};
            wvalid_d     = 1'b1;
            pend_valid_d = 1'b0;
          end
          lane_d  = '0;
          acc_d   = '0;
          state_d = StIdle;
        end
      end
      StOvf: begin
        if (term) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (arm) begin
      lane_d       = '0;
      acc_d        = '0;
      beat_cnt_d   = '0;
      tcnt_d       = '0;
      pend_valid_d = 1'b0;
    end
    if (capture) begin
      tcnt_d = tcnt_q + 1'b1;
      if (lane_last) begin
        lane_d = '0;
        acc_d  = '0;
      end else begin
        lane_d = lane_q + 1'b1;
        acc_d  = beat_full;
      end
    end
    // Gated beats are held one deep so the last one can still be tagged with tlast.
    if (gated && capture && lane_last) begin
      pend_d       = {1'b0, KeepAll, beat_full};
      pend_valid_d = 1'b1;
      if (pend_valid_q) begin
        wbeat_d  = pend_q;
        wvalid_d = 1'b1;
      end
    end
    if (start || start_rt) overflow_d = 1'b0;
    if (drop) begin
      state_d      = StOvf;
      wvalid_d     = 1'b0;
      pend_valid_d = 1'b0;
      lane_d       = '0;
      acc_d        = '0;
      overflow_d   = 1'b1;
      if (ovf_count_q != '1) ovf_count_d = ovf_count_q + 1'b1;
    end
    if (abort) begin
      state_d      = StIdle;
      wvalid_d     = 1'b0;
      pend_valid_d = 1'b0;
      lane_d       = '0;
      acc_d        = '0;
      overflow_d   = 1'b0;
    end
  end

  always_comb begin
    fifo_wr  = wvalid_q || term;
    fifo_din = term ? {1'b1, KeepAll, {DATA_W{1'b0}}} : wbeat_q;
    sr_pc_d  = abort || ((state_q == StIdle) && fifo_empty && !pend_valid_q && !wvalid_q);
    m00_axis_tvalid = !fifo_empty;
    {m00_axis_tlast, m00_axis_tkeep, m00_axis_tdata} = fifo_empty ? '0 : fifo_dout;
    sr_pc     = sr_pc_q;
    overflow  = overflow_q;
    ovf_count = ovf_count_q;
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      lane_q       <= '0;
      acc_q        <= '0;
      beat_cnt_q   <= '0;
      dsize_q      <= '0;
      tcnt_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      wbeat_q      <= '0;
      wvalid_q     <= 1'b0;
      overflow_q   <= 1'b0;
      ovf_count_q  <= '0;
      sr_pc_q      <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      beat_cnt_q   <= beat_cnt_d;
      dsize_q      <= dsize_d;
      tcnt_q       <= tcnt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      wbeat_q      <= wbeat_d;
      wvalid_q     <= wvalid_d;
      overflow_q   <= overflow_d;
      ovf_count_q  <= ovf_count_d;
      sr_pc_q      <= sr_pc_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (m00_axis_aclk),
    .rst_ni (m00_axis_aresetn),
    .clear_i(abort),
    .wr_en_i(fifo_wr),
    .din_i  (fifo_din),
    .full_o (fifo_full),
    .rd_en_i(fifo_rd),
    .dout_o (fifo_dout),
    .empty_o(fifo_empty)
  );

endmodule

// File: doc/adc_stream_packetizer.md
Name: adc_stream_packetizer

Overview:
- Parametrised successor to the single-channel ADC-to-AXI-Stream receiver.
- Packs SAMPLES_PER_BEAT samples of SAMPLE_W bits into each AXI-Stream beat and buffers the beats in an internal synchronous FIFO.
- Frames packets in two modes: fixed-length single-shot, and sync-gated real-time with partial-beat flush and TKEEP marking.
- Sits after the ADC CDC stage, so all ports share m00_axis_aclk. Adds a test-pattern mode and overflow detection with packet termination.

Parameters:
- SAMPLE_W, 16, bits per sample.
- SAMPLES_PER_BEAT, 2, samples per beat. DATA_W = SAMPLE_W*SAMPLES_PER_BEAT, which must be a multiple of 8. KEEP_W = DATA_W/8.
- FIFO_DEPTH, 512, FIFO depth in beats; power of 2, at least 4.
- CNT_W, 32, width of dsize and ovf_count.

Ports:
- m00_axis_aclk  in  1  single clock for the whole block.
- m00_axis_aresetn  in  1  asynchronous, active-low reset.
- s_sample_valid  in  1  s_sample_data is valid this cycle.
- s_sample_data  in  SAMPLE_W  ADC sample, already in the m00_axis_aclk domain.
- m00_axis_tvalid  out  1  AXIS valid.
- m00_axis_tdata  out  DATA_W  AXIS data.
- m00_axis_tkeep  out  KEEP_W  AXIS byte enables.
- m00_axis_tlast  out  1  AXIS end of packet.
- m00_axis_tready  in  1  AXIS ready.
- dsize  in  CNT_W  single-shot packet length in beats; sampled when start is accepted.
- test  in  1  replace sample data with the sample counter.
- start  in  1  one-cycle pulse; arm single-shot capture.
- start_rt  in  1  one-cycle pulse; arm sync-gated capture.
- sync  in  1  level; capture window for real-time mode.
- abort  in  1  synchronous flush.
- sr_pc  out  1  packet complete / block idle.
- overflow  out  1  sticky overflow flag; cleared by start, start_rt or abort.
- ovf_count  out  CNT_W  number of overflows, saturating at its maximum.

Behaviour:
- Reset values: all outputs 0; FIFO empty; lane index 0; state IDLE. sr_pc rises 1 cycle after reset release.
- Packing:
  - Each accepted sample goes into lane k at bits [k*SAMPLE_W +: SAMPLE_W]; lane 0 is filled first.
  - A beat is complete when lane SAMPLES_PER_BEAT-1 is filled.
  - With test=1, lane data is a free-running sample counter truncated to SAMPLE_W. The counter is reset to 0 on arm and advances per accepted sample.
- FIFO entry holds {tlast, tkeep, tdata}. The AXIS outputs are driven directly from the FIFO head (first-word fall-through).
- Head beat is popped on tvalid && tready. tdata, tkeep and tlast stay stable while tvalid && !tready.
- Latency: sample that completes a beat at cycle n → FIFO write at n+1 → tvalid at n+2 when the FIFO was empty. In gated mode, non-final beats wait in the PEND register (see GRUN).
- State machine:
  - IDLE:
    - sr_pc = FIFO empty && PEND empty; samples are ignored.
    - start_rt → GARM. start with dsize≠0 → SRUN. start_rt has priority over start.
    - start with dsize=0 is ignored. start or start_rt outside IDLE is ignored.
  - SRUN:
    - Capture every valid sample.
    - Each complete beat is written with tkeep all ones; the dsize-th beat is written with tlast=1, then → IDLE.
  - GARM: wait for sync=1; samples are ignored. The first valid sample with sync=1 is captured → GRUN.
  - GRUN:
    - Capture while sync=1. Each complete beat goes to the PEND register; the previous PEND contents are written to the FIFO with tlast=0.
    - On the first cycle with sync=0 (that cycle's sample is not captured), close the packet:
      - A partial beat is zero-padded, given tkeep covering the filled lanes, and written with tlast=1 after PEND.
      - Otherwise PEND is written with tlast=1.
      - If nothing was captured, nothing is emitted.
    - → IDLE.
  - OVF:
    - Entered from SRUN or GRUN when a beat must be written while the FIFO is full; that beat is dropped.
    - On entry: overflow=1, ovf_count+1, capture stops.
    - When the FIFO is not full, write one terminator beat (tdata=0, tkeep all ones, tlast=1) → IDLE.
- Simultaneous FIFO pop and push while full: the push succeeds (no overflow).
- abort, any state: next cycle FIFO and PEND are cleared, lanes reset, tvalid=0, overflow=0, state IDLE. This intentionally breaks AXIS protocol and is for recovery only.
- Asynchronous reset mid-packet has the same effect as abort, except ovf_count also resets to 0.

Decomposition:
- Package adc_stream_pkg:
  - state enum {IDLE, SRUN, GARM, GRUN, OVF}.
  - function computing tkeep from the filled-lane count for a given SAMPLE_W.
- Sub-module sync_fifo_fwft:
  - parameters WIDTH and DEPTH; one clock, async active-low reset.
  - ports: wr_en, din, full, rd_en, dout, empty, clear.

Test Plan:
- Single-shot: SAMPLE_W=16, SAMPLES_PER_BEAT=2, dsize=4, samples 0x0001..0x0008 one per cycle, tready=1 → beats 0x00020001, 0x00040003, 0x00060005, 0x00080007; tlast on beat 4 only; tkeep=0xF; first tvalid 2 cycles after sample 0x0002; sr_pc 0 during the packet, 1 after.
- Backpressure: same stimulus, tready alternating 1/0 → identical 4 beats; data held stable during stalls; no loss.
- Gated: start_rt, sync high for 5 samples 0x0011..0x0015 → beats 0x00120011, 0x00140013, 0x00000015 with tkeep=0x3 and tlast=1. A second run with 4 samples → last beat 0x00140013, tkeep=0xF, tlast=1.
- Test mode: test=1, dsize=2, arbitrary samples → 0x00010000, 0x00030002 with tlast on the second beat.
- Overflow: FIFO_DEPTH=16, tready=0, dsize=100, continuous samples → overflow=1, ovf_count=1. Then tready=1 → 16 data beats, then terminator 0x00000000 with tlast=1; sr_pc=1 afterwards.
- Abort/reset: abort at beat 2 of a dsize=8 packet → tvalid=0 next cycle, sr_pc=1. A new start with dsize=2 produces a clean 2-beat packet. Repeat using m00_axis_aresetn low → same result and ovf_count=0.
